// File: rtl/neuron_learn_layer_seq_pkg.sv
// -----------------------------------------------------------------------------
// neuron_learn_layer_seq_pkg
// Shared types and constants for the time-multiplexed learning layer.
//   zero2one_t : 16-bit unsigned, value = raw / 65536
//   frac_t     : 16-bit signed Q2.14
//   state_t    : sequencer states of the layer
// No ports (package).
// -----------------------------------------------------------------------------
package neuron_learn_layer_seq_pkg;

  localparam int DATA_W    = 16;
  // MAC operands are 17-bit signed: a frac_t sign-extended, an error term,
  // or a zero2one_t with a zero sign bit prepended.
  localparam int OPND_W    = DATA_W + 1;
  // Full product plus one guard bit for the accumulate.
  localparam int MAC_SUM_W = 2 * OPND_W + 1;

  typedef logic        [DATA_W-1:0] zero2one_t;
  typedef logic signed [DATA_W-1:0] frac_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_LEARN,
    S_AVG,
    S_RESP
  } state_t;

  localparam frac_t FRAC_MAX = 16'sh7FFF;
  localparam frac_t FRAC_MIN = 16'sh8000;

  // Counter width that stays legal when the count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_learn_layer_seq_mac.sv
// -----------------------------------------------------------------------------
// neuron_learn_layer_seq_mac
// Combinational signed multiply, arithmetic right shift, accumulate and
// optional saturation.
//   i_a, i_b     : 17-bit signed operands
//   i_shift_sel  : 0 -> shift by SHIFT0, 1 -> shift by SHIFT1
//   i_addend     : signed value added to the shifted product
//   i_sat        : clamp the sum to [SAT_LO, SAT_HI] before truncation
//   o_res        : low RES_W bits of the (possibly clamped) sum
// -----------------------------------------------------------------------------
module neuron_learn_layer_seq_mac
  import neuron_learn_layer_seq_pkg::*;
#(
  parameter int ADD_W  = 19,
  parameter int RES_W  = 19,
  parameter int SHIFT0 = 16,
  parameter int SHIFT1 = 16,
  parameter int SAT_LO = -32768,
  parameter int SAT_HI = 32767
) (
  input  logic signed [OPND_W-1:0] i_a,
  input  logic signed [OPND_W-1:0] i_b,
  input  logic                     i_shift_sel,
  input  logic signed [ADD_W-1:0]  i_addend,
  input  logic                     i_sat,
  output logic signed [RES_W-1:0]  o_res
);

  localparam int PROD_W = 2 * OPND_W;
  localparam int SUM_W  = MAC_SUM_W;
  localparam logic signed [SUM_W-1:0] LIM_LO = SUM_W'(SAT_LO);
  localparam logic signed [SUM_W-1:0] LIM_HI = SUM_W'(SAT_HI);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shifted;
  logic signed [SUM_W-1:0]  w_sum;

  assign w_prod    = PROD_W'(i_a) * PROD_W'(i_b);
  assign w_shifted = i_shift_sel ? (w_prod >>> SHIFT1) : (w_prod >>> SHIFT0);
  assign w_sum     = {{(SUM_W-PROD_W){w_shifted[PROD_W-1]}}, w_shifted}
                   + {{(SUM_W-ADD_W){i_addend[ADD_W-1]}}, i_addend};

  always_comb begin
    o_res = w_sum[RES_W-1:0];
    if (i_sat) begin
      if (w_sum > LIM_HI) begin
        o_res = LIM_HI[RES_W-1:0];
      end else if (w_sum < LIM_LO) begin
        o_res = LIM_LO[RES_W-1:0];
      end
    end
  end

endmodule

// File: rtl/neuron_learn_layer_seq.sv
// -----------------------------------------------------------------------------
// neuron_learn_layer_seq
// M neurons x N inputs learning layer sharing one MAC datapath. A request runs
// a forward pass (M*N cycles) and optionally a learning pass (M*N cycles) plus
// one averaging cycle, then presents results until the consumer takes them.
//   clock, reset               : clock, synchronous active-high reset
//   in_valid/in_ready          : request handshake; learn, in, expected_out
//                                are sampled on accept
//   out_valid/out_ready        : result handshake
//   out, expected_in           : neuron outputs, averaged back-prop target
//   weights                    : current weight matrix
//   activation_max/min         : running activation extrema
// Optional feature macro: NEURON_LAYER_MINMAX_EN builds the extrema
// registers; without it both extrema ports are constant 0.
// -----------------------------------------------------------------------------
module neuron_learn_layer_seq
  import neuron_learn_layer_seq_pkg::*;
#(
  parameter int M        = 4,
  parameter int N        = 4,
  parameter int LR_SHIFT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     learn,
  input  zero2one_t [N-1:0]        in,
  input  zero2one_t [M-1:0]        expected_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output zero2one_t [M-1:0]        out,
  output zero2one_t [N-1:0]        expected_in,
  output frac_t     [M-1:0][N-1:0] weights,
  output frac_t     [M-1:0]        activation_max,
  output frac_t     [M-1:0]        activation_min
);

  localparam int ACC_W = DATA_W + $clog2(N) + 1;
  localparam int BPS_W = DATA_W + $clog2(M);
  localparam int MI_W  = cnt_w(M);
  localparam int JI_W  = cnt_w(N);

  state_t                  r_state, w_state_next;
  logic [MI_W-1:0]         r_m;
  logic [JI_W-1:0]         r_j;
  logic                    r_learn;
  logic                    r_out_valid;
  zero2one_t [N-1:0]       r_in;
  zero2one_t [M-1:0]       r_exp_out;
  zero2one_t [M-1:0]       r_out;
  zero2one_t [N-1:0]       r_expected_in;
  frac_t [M-1:0][N-1:0]    r_w;
  logic signed [ACC_W-1:0] r_acc;
  logic [BPS_W-1:0]        r_bp_sum [N];

  logic                     w_last_j, w_last_m, w_last_pair, w_is_learn;
  frac_t                    w_w_cur;
  zero2one_t                w_in_cur;
  logic signed [OPND_W-1:0] w_err, w_w_ext, w_in_ext, w_mac_a;
  logic signed [ACC_W-1:0]  w_mac_add, w_mac_res;
  frac_t                    w_act;
  zero2one_t                w_act_out;
  logic [DATA_W-1:0]        w_bp_res;
  zero2one_t [N-1:0]        w_avg;

  assign w_last_j    = (r_j == JI_W'(N - 1));
  assign w_last_m    = (r_m == MI_W'(M - 1));
  assign w_last_pair = w_last_j && w_last_m;
  assign w_is_learn  = (r_state == S_LEARN);

  assign w_w_cur  = r_w[r_m][r_j];
  assign w_in_cur = r_in[r_j];
  assign w_w_ext  = {w_w_cur[DATA_W-1], w_w_cur};
  assign w_in_ext = {1'b0, w_in_cur};
  // Error wraps into 17 bits; the two's-complement result is the signed error.
  assign w_err    = {1'b0, r_exp_out[r_m]} - {1'b0, r_out[r_m]};

  // Shared MAC: FWD computes acc + w*in >>> 16; LEARN computes w + e*in >>> (18+LR).
  assign w_mac_a   = w_is_learn ? w_err : w_w_ext;
  assign w_mac_add = w_is_learn ? {{(ACC_W-DATA_W){w_w_cur[DATA_W-1]}}, w_w_cur}
                                : ((r_j == '0) ? '0 : r_acc);

  neuron_learn_layer_seq_mac #(
    .ADD_W (ACC_W),
    .RES_W (ACC_W),
    .SHIFT0(16),
    .SHIFT1(18 + LR_SHIFT),
    .SAT_LO(-32768),
    .SAT_HI(32767)
  ) u_mac (
    .i_a        (w_mac_a),
    .i_b        (w_in_ext),
    .i_shift_sel(w_is_learn),
    .i_addend   (w_mac_add),
    .i_sat      (w_is_learn || w_last_j),
    .o_res      (w_mac_res)
  );

  // Back-propagation term: clamp(in + e*w_old >>> (14+LR), 0, 0xFFFF).
  neuron_learn_layer_seq_mac #(
    .ADD_W (OPND_W),
    .RES_W (DATA_W),
    .SHIFT0(14 + LR_SHIFT),
    .SHIFT1(14 + LR_SHIFT),
    .SAT_LO(0),
    .SAT_HI(65535)
  ) u_bp_mac (
    .i_a        (w_err),
    .i_b        (w_w_ext),
    .i_shift_sel(1'b0),
    .i_addend   (w_in_ext),
    .i_sat      (1'b1),
    .o_res      (w_bp_res)
  );

  // Activation is already saturated to frac_t on the last input of a neuron.
  // Negative -> 0, >= 1.0 (bit 14 set) -> full scale, else Q2.14 -> Q0.16.
  assign w_act     = w_mac_res[DATA_W-1:0];
  assign w_act_out = w_act[DATA_W-1] ? '0 :
                     w_act[DATA_W-2] ? '1 : {w_act[DATA_W-3:0], 2'b00};

  for (genvar gi = 0; gi < N; gi++) begin : g_avg
    assign w_avg[gi] = DATA_W'(r_bp_sum[gi] / BPS_W'(M));
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_FWD;
      S_FWD:   if (w_last_pair) w_state_next = r_learn ? S_LEARN : S_RESP;
      S_LEARN: if (w_last_pair) w_state_next = S_AVG;
      S_AVG:   w_state_next = S_RESP;
      S_RESP:  if (r_out_valid && out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_m           <= '0;
      r_j           <= '0;
      r_learn       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_in          <= '0;
      r_exp_out     <= '0;
      r_out         <= '0;
      r_expected_in <= '0;
      r_w           <= '0;
      r_acc         <= '0;
      for (int k = 0; k < N; k++) r_bp_sum[k] <= '0;
    end else begin
      r_state     <= w_state_next;
      // Registered one cycle into RESP so outputs are settled when it rises.
      r_out_valid <= (r_state == S_RESP) && !(r_out_valid && out_ready);
      unique case (r_state)
        S_IDLE: begin
          r_m <= '0;
          r_j <= '0;
          if (in_valid) begin
            r_in      <= in;
            r_exp_out <= expected_out;
            r_learn   <= learn;
            if (!learn) r_expected_in <= in;
          end
        end
        S_FWD, S_LEARN: begin
          if (w_last_j) begin
            r_j <= '0;
            r_m <= w_last_m ? '0 : r_m + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
          if (!w_is_learn) begin
            if (w_last_j) r_out[r_m] <= w_act_out;
            else          r_acc      <= w_mac_res;
          end else begin
            r_w[r_m][r_j] <= w_mac_res[DATA_W-1:0];
            r_bp_sum[r_j] <= ((r_m == '0) ? '0 : r_bp_sum[r_j]) + BPS_W'(w_bp_res);
          end
        end
        S_AVG:   r_expected_in <= w_avg;
        default: ;
      endcase
    end
  end

`ifdef NEURON_LAYER_MINMAX_EN
  frac_t [M-1:0] r_act_max;
  frac_t [M-1:0] r_act_min;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_act_max <= {M{FRAC_MIN}};
      r_act_min <= {M{FRAC_MAX}};
    end else if (r_state == S_FWD && w_last_j) begin
      if ($signed(w_act) > $signed(r_act_max[r_m])) r_act_max[r_m] <= w_act;
      if ($signed(w_act) < $signed(r_act_min[r_m])) r_act_min[r_m] <= w_act;
    end
  end

  assign activation_max = r_act_max;
  assign activation_min = r_act_min;
`else
  assign activation_max = '0;
  assign activation_min = '0;
`endif

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign out         = r_out;
  assign expected_in = r_expected_in;
  assign weights     = r_w;

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_neuron_learn_layer_seq
// Self-checking bench for neuron_learn_layer_seq (M=N=4, LR_SHIFT=2) against
// an integer reference model of the layer arithmetic.
// -----------------------------------------------------------------------------
module tb_neuron_learn_layer_seq;
  import neuron_learn_layer_seq_pkg::*;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int LR = 2;
  localparam int MN = M * N;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, learn, out_valid, out_ready;
  zero2one_t [N-1:0]        din;
  zero2one_t [M-1:0]        dexp;
  zero2one_t [M-1:0]        dout;
  zero2one_t [N-1:0]        dein;
  frac_t     [M-1:0][N-1:0] dw;
  frac_t     [M-1:0]        amax, amin;

  int checks = 0;
  int errors = 0;

  // Reference state
  int mw [M][N];
  int mmax [M];
  int mmin [M];
  int mout [M];
  int mein [N];
  int sin_ [N];
  int sexp [M];

  always #5 clock = ~clock;

  neuron_learn_layer_seq #(.M(M), .N(N), .LR_SHIFT(LR)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .learn         (learn),
    .in            (din),
    .expected_out  (dexp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out           (dout),
    .expected_in   (dein),
    .weights       (dw),
    .activation_max(amax),
    .activation_min(amin)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      for (int j = 0; j < N; j++) mw[m][j] = 0;
      mmax[m] = -32768;
      mmin[m] = 32767;
      mout[m] = 0;
    end
    for (int j = 0; j < N; j++) mein[j] = 0;
  endtask

  // Transaction model: real-valued layer maths on integers, floor shifts.
  task automatic model_txn(input bit lrn);
    longint acc, act, e, wold;
    longint s [N];
    for (int m = 0; m < M; m++) begin
      acc = 0;
      for (int j = 0; j < N; j++) acc += (longint'(mw[m][j]) * sin_[j]) >>> 16;
      act = clampl(acc, -32768, 32767);
      mout[m] = (act < 0) ? 0 : ((act >= 16384) ? 65535 : int'(act * 4));
      if (act > mmax[m]) mmax[m] = int'(act);
      if (act < mmin[m]) mmin[m] = int'(act);
    end
    if (!lrn) begin
      for (int j = 0; j < N; j++) mein[j] = sin_[j];
    end else begin
      for (int j = 0; j < N; j++) s[j] = 0;
      for (int m = 0; m < M; m++) begin
        e = longint'(sexp[m]) - mout[m];
        for (int j = 0; j < N; j++) begin
          wold = mw[m][j];
          mw[m][j] = int'(clampl(wold + ((e * sin_[j]) >>> (18 + LR)), -32768, 32767));
          s[j] += clampl(sin_[j] + ((e * wold) >>> (14 + LR)), 0, 65535);
        end
      end
      for (int j = 0; j < N; j++) mein[j] = int'(s[j] / M);
    end
  endtask

  task automatic check_data(input string ctx, input bit full);
    logic [15:0] ob, ex;
    for (int m = 0; m < M; m++) chk($sformatf("%s out[%0d]", ctx, m), dout[m], mout[m]);
    for (int j = 0; j < N; j++) chk($sformatf("%s expected_in[%0d]", ctx, j), dein[j], mein[j]);
    if (full) begin
      for (int m = 0; m < M; m++) begin
        for (int j = 0; j < N; j++) begin
          ob = dw[m][j];
          ex = mw[m][j][15:0];
          chk($sformatf("%s w[%0d][%0d]", ctx, m, j), ob, ex);
        end
        ob = amax[m];
`ifdef NEURON_LAYER_MINMAX_EN
        ex = mmax[m][15:0];
`else
        ex = 16'h0000;
`endif
        chk($sformatf("%s act_max[%0d]", ctx, m), ob, ex);
        ob = amin[m];
`ifdef NEURON_LAYER_MINMAX_EN
        ex = mmin[m][15:0];
`else
        ex = 16'h0000;
`endif
        chk($sformatf("%s act_min[%0d]", ctx, m), ob, ex);
      end
    end
  endtask

  task automatic check_reset(input string ctx);
    chk({ctx, " in_ready"}, in_ready, 1);
    chk({ctx, " out_valid"}, out_valid, 0);
    check_data(ctx, 1'b1);
  endtask

  task automatic run_txn(input string ctx, input bit lrn, input int hold);
    int cyc;
    chk({ctx, " in_ready idle"}, in_ready, 1);
    for (int j = 0; j < N; j++) din[j] = sin_[j][15:0];
    for (int m = 0; m < M; m++) dexp[m] = sexp[m][15:0];
    learn    = lrn;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int j = 0; j < N; j++) din[j] = 16'($urandom);
    for (int m = 0; m < M; m++) dexp[m] = 16'($urandom);
    learn = ~lrn;
    model_txn(lrn);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk({ctx, " latency"}, cyc, lrn ? (2 * MN + 2) : (MN + 1));
    chk({ctx, " in_ready busy"}, in_ready, 0);
    check_data(ctx, 1'b1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      for (int j = 0; j < N; j++) din[j] = 16'($urandom);
      @(posedge clock); #1;
      chk({ctx, " hold out_valid"}, out_valid, 1);
      chk({ctx, " hold in_ready"}, in_ready, 0);
      check_data({ctx, " hold"}, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({ctx, " out_valid drop"}, out_valid, 0);
    chk({ctx, " in_ready back"}, in_ready, 1);
    $display("txn %s learn=%0d latency=%0d out0=0x%0h ein0=0x%0h", ctx, lrn, cyc, dout[0], dein[0]);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    learn     = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    dexp      = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset("after_reset");

    // Half-scale inputs, zero weights, forward only.
    for (int j = 0; j < N; j++) sin_[j] = 32768;
    for (int m = 0; m < M; m++) sexp[m] = int'($urandom_range(0, 65535));
    run_txn("fwd_half", 1'b0, 0);

    // Full-scale learn from zero weights.
    for (int j = 0; j < N; j++) sin_[j] = 65535;
    for (int m = 0; m < M; m++) sexp[m] = 65535;
    run_txn("learn_full", 1'b1, 0);
    run_txn("fwd_full", 1'b0, 0);

    // Repeated learning toward full-scale targets.
    for (int t = 0; t < 20; t++) begin
      for (int j = 0; j < N; j++) sin_[j] = int'($urandom_range(0, 65535));
      for (int m = 0; m < M; m++) sexp[m] = 65535;
      run_txn($sformatf("learn_hi%0d", t), 1'b1, 0);
    end

    // Mixed random transactions.
    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < N; j++) sin_[j] = int'($urandom_range(0, 65535));
      for (int m = 0; m < M; m++) sexp[m] = int'($urandom_range(0, 65535));
      run_txn($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 0);
    end

    // Back-pressure in RESP with stray in_valid.
    for (int j = 0; j < N; j++) sin_[j] = int'($urandom_range(0, 65535));
    run_txn("hold", 1'b0, 10);
    @(posedge clock); #1;
    chk("hold idle stays", in_ready, 1);

    // Reset in the middle of LEARN.
    for (int j = 0; j < N; j++) din[j] = 16'($urandom);
    for (int m = 0; m < M; m++) dexp[m] = 16'($urandom);
    learn    = 1'b1;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (MN + 5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    check_reset("mid_learn_reset");
    $display("txn mid_learn_reset in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // Normal operation resumes from cleared weights.
    for (int j = 0; j < N; j++) sin_[j] = int'($urandom_range(0, 65535));
    for (int m = 0; m < M; m++) sexp[m] = int'($urandom_range(0, 65535));
    run_txn("post_reset", 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
